// File: rtl/ntcrack_host.sv
// ntcrack_host - host-side driver for the ntcrackfpga byte handshake.
//
// Purpose:
//   Accepts a byte stream of 16-byte NT hashes and hands them to the cracker one byte at a time
//   over the store_hash_byte/your_turn handshake. After the final hash it issues go. It then
//   collects 21-byte match records (20 password characters plus a length byte) through the
//   match_found/go acknowledge handshake. Each record is replayed on a ready/valid byte stream.
//
// Parameters:
//   HASH_MAX        hash capacity of the cracker's checker; further hashes are dropped (<= 255)
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-high reset
//   in_byte/in_valid/in_last/in_ready   hash byte stream from the host
//   new_hash_byte, store_hash_byte, go  commands to the cracker
//   your_turn, match_found, password_byte  status and record bytes from the cracker
//   out_byte/out_valid/out_ready        result byte stream (e.g. to a UART transmitter)
//   cracking        go has been issued; collection phase
//   hash_count      complete hashes forwarded, saturating at HASH_MAX
//   match_count     records completed, wrapping
//   err             sticky protocol error
//
// Build option:
//   NTCRACK_HOST_TRIM_EN  when defined, each record is sent as rec[0..len-1] followed by 0x0A,
//                         with len = rec[20][4:0] clamped to 20 (clamping sets err). Otherwise
//                         all 21 record bytes are sent raw.

module ntcrack_host #(
  parameter int unsigned HASH_MAX = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  new_hash_byte,
  output logic        store_hash_byte,
  output logic        go,
  input  logic        your_turn,
  input  logic        match_found,
  input  logic [7:0]  password_byte,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        cracking,
  output logic [7:0]  hash_count,
  output logic [15:0] match_count,
  output logic        err
);

  localparam logic [7:0] HashMax = HASH_MAX[7:0];
  localparam logic [4:0] RecLast = 5'd20;

  typedef enum logic [2:0] {StLoad, StStore, StGo, StCollect, StEmit} state_e;

  state_e      state_q, state_d;
  logic [7:0]  hash_byte_q, hash_byte_d;
  logic        last_q, last_d;
  logic        store_q, store_d;
  logic        go_q, go_d;
  logic [3:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  hash_count_q, hash_count_d;
  logic [15:0] match_count_q, match_count_d;
  logic        cracking_q, cracking_d;
  logic        err_q, err_d;
  logic [4:0]  rec_idx_q, rec_idx_d;
  logic [4:0]  emit_idx_q, emit_idx_d;
  logic        out_valid_q, out_valid_d;
  logic        run_q;
  logic        rec_we;

  // Record buffer; contents are don't-care across reset.
  logic [7:0]  rec_q [21];

  logic        accept;
  logic        full;
  logic        go_done;
  logic        ack_take;
  logic        ack_done;
  logic        out_fire;
  logic        emit_last;
  logic        len_bad;
  logic [4:0]  emit_len;
  logic [7:0]  emit_data;

  // run_q holds in_ready low for the first cycle after reset so every output is 0 in reset.
  assign in_ready = run_q && (state_q == StLoad) && your_turn;
  assign accept   = in_valid && in_ready;
  assign full     = (hash_count_q == HashMax);
  assign go_done  = (state_q == StGo) && go_q && !your_turn;
  assign ack_take = (state_q == StCollect) && !go_q && your_turn && match_found;
  assign ack_done = (state_q == StCollect) && go_q && !your_turn;
  assign out_fire = out_valid_q && out_ready;

`ifdef NTCRACK_HOST_TRIM_EN
  // emit_idx runs 0..len; the position equal to len carries the newline terminator.
  assign len_bad   = (rec_q[RecLast][4:0] > RecLast);
  assign emit_len  = len_bad ? RecLast : rec_q[RecLast][4:0];
  assign emit_data = (emit_idx_q == emit_len) ? 8'h0A : rec_q[emit_idx_q];
`else
  assign len_bad   = 1'b0;
  assign emit_len  = RecLast;
  assign emit_data = rec_q[emit_idx_q];
`endif

  assign emit_last = (emit_idx_q == emit_len);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StLoad;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StLoad: begin
        if (accept) begin
          if (!full) begin
            state_d = StStore;
          end else if (in_last) begin
            state_d = StGo;
          end
        end
      end
      StStore: begin
        if (!your_turn) begin
          state_d = (last_q && (byte_idx_q == 4'd15)) ? StGo : StLoad;
        end
      end
      StGo: begin
        if (go_done) begin
          state_d = StCollect;
        end
      end
      StCollect: begin
        if (ack_done && (rec_idx_q == RecLast)) begin
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (out_fire && emit_last) begin
          state_d = StCollect;
        end
      end
      default: state_d = StLoad;
    endcase
  end

  // Output and datapath next-state logic.
  always_comb begin
    hash_byte_d   = hash_byte_q;
    last_d        = last_q;
    store_d       = store_q;
    go_d          = go_q;
    byte_idx_d    = byte_idx_q;
    hash_count_d  = hash_count_q;
    match_count_d = match_count_q;
    cracking_d    = cracking_q;
    err_d         = err_q;
    rec_idx_d     = rec_idx_q;
    emit_idx_d    = emit_idx_q;
    out_valid_d   = out_valid_q;
    rec_we        = 1'b0;
    case (state_q)
      StLoad: begin
        if (accept) begin
          hash_byte_d = in_byte;
          last_d      = in_last;
          if (full) begin
            // Beyond capacity: the byte is swallowed and never reaches the cracker.
            err_d = 1'b1;
          end else begin
            store_d = 1'b1;
          end
        end
      end
      StStore: begin
        if (!your_turn) begin
          store_d    = 1'b0;
          byte_idx_d = byte_idx_q + 4'd1;
          if ((byte_idx_q == 4'd15) && !full) begin
            hash_count_d = hash_count_q + 8'd1;
          end
          if (last_q && (byte_idx_q != 4'd15)) begin
            err_d = 1'b1;
          end
        end
      end
      StGo: begin
        if (!go_q && your_turn) begin
          go_d = 1'b1;
        end else if (go_done) begin
          go_d       = 1'b0;
          cracking_d = 1'b1;
        end
      end
      StCollect: begin
        if (ack_take) begin
          rec_we = 1'b1;
          go_d   = 1'b1;
        end else if (ack_done) begin
          go_d = 1'b0;
          if (rec_idx_q == RecLast) begin
            rec_idx_d     = 5'd0;
            match_count_d = match_count_q + 16'd1;
            emit_idx_d    = 5'd0;
          end else begin
            rec_idx_d = rec_idx_q + 5'd1;
          end
        end
      end
      StEmit: begin
        if (len_bad) begin
          err_d = 1'b1;
        end
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
        end else if (out_fire) begin
          if (emit_last) begin
            out_valid_d = 1'b0;
          end else begin
            emit_idx_d = emit_idx_q + 5'd1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hash_byte_q   <= 8'd0;
      last_q        <= 1'b0;
      store_q       <= 1'b0;
      go_q          <= 1'b0;
      byte_idx_q    <= 4'd0;
      hash_count_q  <= 8'd0;
      match_count_q <= 16'd0;
      cracking_q    <= 1'b0;
      err_q         <= 1'b0;
      rec_idx_q     <= 5'd0;
      emit_idx_q    <= 5'd0;
      out_valid_q   <= 1'b0;
      run_q         <= 1'b0;
    end else begin
      hash_byte_q   <= hash_byte_d;
      last_q        <= last_d;
      store_q       <= store_d;
      go_q          <= go_d;
      byte_idx_q    <= byte_idx_d;
      hash_count_q  <= hash_count_d;
      match_count_q <= match_count_d;
      cracking_q    <= cracking_d;
      err_q         <= err_d;
      rec_idx_q     <= rec_idx_d;
      emit_idx_q    <= emit_idx_d;
      out_valid_q   <= out_valid_d;
      run_q         <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rec_we) begin
      rec_q[rec_idx_q] <= password_byte;
    end
  end

  assign new_hash_byte   = hash_byte_q;
  assign store_hash_byte = store_q;
  assign go              = go_q;
  assign out_valid       = out_valid_q;
  // Gate with valid so the unreset record buffer never shows through during reset.
  assign out_byte        = out_valid_q ? emit_data : 8'd0;
  assign cracking        = cracking_q;
  assign hash_count      = hash_count_q;
  assign match_count     = match_count_q;
  assign err             = err_q;

endmodule
